// File: rtl/spidergon_output_port_arbiter.sv
// Round-robin wormhole arbiter for one spidergon output port.
// Grants one head-of-line flit per cycle and holds the port for a packet from HEAD to TAIL.
module spidergon_output_port_arbiter #(
    parameter  int NUM_OF_REQUESTERS       = 4,
    parameter  int NUM_OF_VIRTUAL_CHANNELS = 2,
    localparam int VC_W = (NUM_OF_VIRTUAL_CHANNELS > 1) ? $clog2(NUM_OF_VIRTUAL_CHANNELS) : 1,
    localparam int OW   = (NUM_OF_REQUESTERS > 1) ? $clog2(NUM_OF_REQUESTERS) : 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_OF_REQUESTERS-1:0]        req_valid,
    input  logic [2*NUM_OF_REQUESTERS-1:0]      req_flit_type,
    input  logic [VC_W*NUM_OF_REQUESTERS-1:0]   req_vc,
    input  logic [NUM_OF_VIRTUAL_CHANNELS-1:0]  adjacent_node_vc_are_full,
    output logic [NUM_OF_REQUESTERS-1:0]        grant,
    output logic [VC_W-1:0]                     grant_vc,
    output logic                                flit_output_valid,
    output logic                                port_locked,
    output logic [OW-1:0]                       lock_owner,
    output logic                                protocol_error
);

    localparam logic [1:0] TAIL   = 2'b00;
    localparam logic [1:0] HEAD   = 2'b01;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state, next_state;
    logic [OW-1:0]   rr_ptr, next_rr;
    logic [OW-1:0]   next_owner;
    logic [VC_W-1:0] locked_vc, next_locked_vc;
    logic            tail_gap, next_gap;
    logic            set_error;

    logic [1:0]      flit_type [NUM_OF_REQUESTERS];
    logic [VC_W-1:0] vc_of     [NUM_OF_REQUESTERS];
    logic [NUM_OF_REQUESTERS-1:0] eligible;

    logic [OW-1:0]   idx, winner;
    logic            found;

    always_comb begin
        for (int i = 0; i < NUM_OF_REQUESTERS; i++) begin
            flit_type[i] = req_flit_type[2*i +: 2];
            vc_of[i]     = req_vc[VC_W*i +: VC_W];
            eligible[i]  = req_valid[i] && !adjacent_node_vc_are_full[vc_of[i]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            lock_owner     <= '0;
            locked_vc      <= '0;
            tail_gap       <= 1'b0;
            protocol_error <= 1'b0;
        end else begin
            state          <= next_state;
            rr_ptr         <= next_rr;
            lock_owner     <= next_owner;
            locked_vc      <= next_locked_vc;
            tail_gap       <= next_gap;
            protocol_error <= protocol_error | set_error;
        end
    end

    // Bit 0 of the flit type marks a packet start (HEAD or HEADER); the
    // cycle after a TAIL is kept grant-free so a tail and a head never abut.
    always_comb begin
        grant          = '0;
        grant_vc       = '0;
        next_state     = state;
        next_rr        = rr_ptr;
        next_owner     = lock_owner;
        next_locked_vc = locked_vc;
        next_gap       = 1'b0;
        set_error      = 1'b0;
        found          = 1'b0;
        winner         = '0;
        idx            = '0;

        case (state)
            IDLE: begin
                for (int i = 0; i < NUM_OF_REQUESTERS; i++) begin
                    if (req_valid[i] && !flit_type[i][0])
                        set_error = 1'b1;
                end
                if (!tail_gap) begin
                    for (int off = 0; off < NUM_OF_REQUESTERS; off++) begin
                        idx = OW'((int'(rr_ptr) + off) % NUM_OF_REQUESTERS);
                        if (!found && eligible[idx] && flit_type[idx][0]) begin
                            found  = 1'b1;
                            winner = idx;
                        end
                    end
                end
                if (found) begin
                    grant[winner] = 1'b1;
                    grant_vc      = vc_of[winner];
                    next_rr       = OW'((int'(winner) + 1) % NUM_OF_REQUESTERS);
                    if (flit_type[winner] == HEAD) begin
                        next_state     = LOCKED;
                        next_owner     = winner;
                        next_locked_vc = vc_of[winner];
                    end
                end
            end
            LOCKED: begin
                if (req_valid[lock_owner]) begin
                    if (flit_type[lock_owner][0] || vc_of[lock_owner] != locked_vc) begin
                        set_error = 1'b1;
                    end else if (!adjacent_node_vc_are_full[locked_vc]) begin
                        grant[lock_owner] = 1'b1;
                        grant_vc          = locked_vc;
                        if (flit_type[lock_owner] == TAIL) begin
                            next_state = IDLE;
                            next_owner = '0;
                            next_gap   = 1'b1;
                        end
                    end
                end
            end
            default: next_state = IDLE;
        endcase

        if (reset) begin
            grant    = '0;
            grant_vc = '0;
        end
    end

    assign flit_output_valid = |grant;
    assign port_locked       = (state == LOCKED);

endmodule
